// File: rtl/tetris_game_ctrl.sv
// Tetris game sequencer: owns the locked playfield and the single falling piece.
// Optional feature macro: HARD_DROP_EN (hard-drop key serviced through a DROP state).
module tetris_game_ctrl #(
  parameter int ROWS      = 20,
  parameter int COLS      = 20,
  parameter int SPAWN_COL = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 left_key,
  input  logic                 right_key,
  input  logic                 rotate_key,
  input  logic                 drop_tick,
  input  logic                 hard_drop,
  input  logic [2:0]           random,
  output logic [ROWS*COLS-1:0] field,
  output logic [2:0]           piece_type,
  output logic [15:0]          lines_cleared,
  output logic                 game_over
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS + 1) + 1;
  localparam int CW = $clog2(COLS + 4) + 2;

  localparam int P_TICK  = 0;
  localparam int P_ROT   = 1;
  localparam int P_LEFT  = 2;
  localparam int P_RIGHT = 3;
  localparam int P_HARD  = 4;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SPAWN       = 3'd1,
    S_PLAY        = 3'd2,
    S_LOCK        = 3'd3,
    S_CLEAR_SCAN  = 3'd4,
    S_CLEAR_SHIFT = 3'd5,
    S_GAME_OVER   = 3'd6
`ifdef HARD_DROP_EN
    , S_DROP      = 3'd7
`endif
  } state_e;

  // 4x4 box masks, bit index = box_row*4 + box_col
  function automatic logic [15:0] base_mask(input logic [2:0] t);
    logic [15:0] m;
    case (t)
      3'd0:    m = 16'h0066;
      3'd1:    m = 16'h00F0;
      3'd2:    m = 16'h0072;
      3'd3:    m = 16'h0074;
      3'd4:    m = 16'h0036;
      default: m = 16'h0066;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] rotate_cw(input logic [15:0] m, input logic [2:0] t);
    logic [15:0] r;
    r = 16'h0000;
    if (t == 3'd0) begin
      r = m;
    end else if (t == 3'd1) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (m[i*4+j]) r[j*4+(3-i)] = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          if (m[i*4+j]) r[j*4+(2-i)] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [15:0] piece_mask(input logic [2:0] t, input logic [1:0] rot);
    logic [15:0] m;
    m = base_mask(t);
    for (int k = 0; k < 3; k++)
      if (k < int'(rot)) m = rotate_cw(m, t);
    return m;
  endfunction

  function automatic logic off_field(input logic [15:0] m, input int row, input int col);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (m[i*4+j] && (col + j < 0 || col + j >= COLS || row + i >= ROWS)) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [N-1:0] place(input logic [15:0] m, input int row, input int col);
    logic [N-1:0] f;
    f = {N{1'b0}};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (m[i*4+j] && col + j >= 0 && col + j < COLS && row + i < ROWS)
          f[(row + i) * COLS + col + j] = 1'b1;
    return f;
  endfunction

  state_e               state_q, state_d;
  logic [N-1:0]         locked_q, locked_d, field_q, field_d;
  logic                 valid_q, valid_d;
  logic [2:0]           type_q, type_d;
  logic [1:0]           rot_q, rot_d;
  logic [RW-1:0]        row_q, row_d, scan_q, scan_d;
  logic signed [CW-1:0] col_q, col_d;
  logic [15:0]          lines_q, lines_d;
  logic                 over_q, over_d;
  logic [4:0]           keys_q, keys_d, pend_q, pend_d;
  logic [4:0]           key_edge_s, serviced_s;
  logic                 clear_pend_s;
  logic [2:0]           spawn_type_s, cand_type_s;
  logic [1:0]           cand_rot_s;
  logic [RW-1:0]        cand_row_s;
  logic signed [CW-1:0] cand_col_s;
  logic [15:0]          cand_mask_s;
  logic                 collide_s, row_full_s;
  logic [N-1:0]         cur_cells_s, next_cells_s;

  assign spawn_type_s = (random >= 3'd5) ? (random - 3'd5) : random;
  assign cand_mask_s  = piece_mask(cand_type_s, cand_rot_s);
  assign collide_s    = off_field(cand_mask_s, int'(cand_row_s), int'(cand_col_s)) |
                        (|(place(cand_mask_s, int'(cand_row_s), int'(cand_col_s)) & locked_q));
  assign row_full_s   = &locked_q[int'(scan_q)*COLS +: COLS];
  assign cur_cells_s  = place(piece_mask(type_q, rot_q), int'(row_q), int'(col_q));
  assign next_cells_s = place(piece_mask(type_d, rot_d), int'(row_d), int'(col_d));

  // Candidate position fed to the single collision checker
  always_comb begin
    cand_type_s = type_q;
    cand_rot_s  = rot_q;
    cand_row_s  = row_q;
    cand_col_s  = col_q;
    case (state_q)
      S_SPAWN: begin
        cand_type_s = spawn_type_s;
        cand_rot_s  = 2'd0;
        cand_row_s  = {RW{1'b0}};
        cand_col_s  = CW'(SPAWN_COL);
      end
      S_PLAY: begin
        if (pend_q[P_TICK])       cand_row_s = row_q + RW'(1);
        else if (pend_q[P_ROT])   cand_rot_s = rot_q + 2'd1;
        else if (pend_q[P_LEFT])  cand_col_s = col_q - CW'(1);
        else if (pend_q[P_RIGHT]) cand_col_s = col_q + CW'(1);
        else                      cand_row_s = row_q;
      end
`ifdef HARD_DROP_EN
      S_DROP:  cand_row_s = row_q + RW'(1);
`endif
      default: cand_row_s = row_q;
    endcase
  end

  // Sequencer next state and piece position
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    type_d       = type_q;
    rot_d        = rot_q;
    row_d        = row_q;
    col_d        = col_q;
    scan_d       = scan_q;
    lines_d      = lines_q;
    over_d       = over_q;
    serviced_s   = 5'd0;
    clear_pend_s = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_SPAWN;
      S_SPAWN: begin
        type_d = spawn_type_s;
        rot_d  = 2'd0;
        row_d  = {RW{1'b0}};
        col_d  = CW'(SPAWN_COL);
        if (collide_s) begin
          state_d = S_GAME_OVER;
          over_d  = 1'b1;
        end else begin
          valid_d      = 1'b1;
          clear_pend_s = 1'b1;
          state_d      = S_PLAY;
        end
      end
      S_PLAY: begin
`ifdef HARD_DROP_EN
        if (pend_q[P_HARD]) begin
          serviced_s[P_HARD] = 1'b1;
          state_d            = S_DROP;
        end else
`endif
        if (pend_q[P_TICK]) begin
          serviced_s[P_TICK] = 1'b1;
          if (collide_s) state_d = S_LOCK;
          else           row_d   = cand_row_s;
        end else if (pend_q[P_ROT]) begin
          serviced_s[P_ROT] = 1'b1;
          if (!collide_s) rot_d = cand_rot_s;
          else            rot_d = rot_q;
        end else if (pend_q[P_LEFT]) begin
          serviced_s[P_LEFT] = 1'b1;
          if (!collide_s) col_d = cand_col_s;
          else            col_d = col_q;
        end else if (pend_q[P_RIGHT]) begin
          serviced_s[P_RIGHT] = 1'b1;
          if (!collide_s) col_d = cand_col_s;
          else            col_d = col_q;
        end else begin
          state_d = S_PLAY;
        end
      end
`ifdef HARD_DROP_EN
      S_DROP: begin
        if (collide_s) state_d = S_LOCK;
        else           row_d   = cand_row_s;
      end
`endif
      S_LOCK: begin
        valid_d = 1'b0;
        scan_d  = RW'(ROWS - 1);
        state_d = S_CLEAR_SCAN;
      end
      S_CLEAR_SCAN: begin
        if (row_full_s)                state_d = S_CLEAR_SHIFT;
        else if (scan_q == {RW{1'b0}}) state_d = S_SPAWN;
        else                           scan_d  = scan_q - RW'(1);
      end
      S_CLEAR_SHIFT: begin
        lines_d = (lines_q == 16'hFFFF) ? lines_q : lines_q + 16'd1;
        state_d = S_CLEAR_SCAN;
      end
      S_GAME_OVER: state_d = S_GAME_OVER;
      default:     state_d = S_IDLE;
    endcase
  end

  // Locked playfield: merge on lock, collapse rows above a full row on shift
  always_comb begin
    locked_d = locked_q;
    case (state_q)
      S_LOCK: locked_d = locked_q | cur_cells_s;
      S_CLEAR_SHIFT: begin
        for (int r = 0; r < ROWS; r++) begin
          if (r == 0)                  locked_d[0 +: COLS]      = {COLS{1'b0}};
          else if (r <= int'(scan_q))  locked_d[r*COLS +: COLS] = locked_q[(r-1)*COLS +: COLS];
          else                         locked_d[r*COLS +: COLS] = locked_q[r*COLS +: COLS];
        end
      end
      default: locked_d = locked_q;
    endcase
  end

  // Key edge capture and pending-flag bookkeeping; displayed field
  always_comb begin
    keys_d     = {hard_drop, right_key, left_key, rotate_key, drop_tick};
    key_edge_s = keys_d & ~keys_q;
    if (state_q == S_GAME_OVER) pend_d = pend_q;
    else if (clear_pend_s)      pend_d = 5'd0;
    else                        pend_d = (pend_q & ~serviced_s) | key_edge_s;
    if (state_q == S_GAME_OVER) field_d = field_q;
    else if (valid_d)           field_d = locked_d | next_cells_s;
    else                        field_d = locked_d;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      locked_q <= {N{1'b0}};
      field_q  <= {N{1'b0}};
      valid_q  <= 1'b0;
      type_q   <= 3'd0;
      rot_q    <= 2'd0;
      row_q    <= {RW{1'b0}};
      col_q    <= {CW{1'b0}};
      scan_q   <= {RW{1'b0}};
      lines_q  <= 16'd0;
      over_q   <= 1'b0;
      keys_q   <= 5'd0;
      pend_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      field_q  <= field_d;
      valid_q  <= valid_d;
      type_q   <= type_d;
      rot_q    <= rot_d;
      row_q    <= row_d;
      col_q    <= col_d;
      scan_q   <= scan_d;
      lines_q  <= lines_d;
      over_q   <= over_d;
      keys_q   <= keys_d;
      pend_q   <= pend_d;
    end
  end

  assign field         = field_q;
  assign piece_type    = type_q;
  assign lines_cleared = lines_q;
  assign game_over     = over_q;
endmodule

// File: doc/tetris_game_ctrl.md
Name: tetris_game_ctrl

Overview:
- Game sequencer for the VGA Tetris datapath.
- Owns the locked playfield and the single falling piece.
- Consumes debounced key levels from the keyboard processing, a gravity tick and the LFSR random value.
- Sequences spawn, move, rotate, gravity, lock, line clear and game over, and drives the flattened field vector read by the VGA controller.

Parameters:
- ROWS, 20, playfield rows; row 0 is the top.
- COLS, 20, playfield columns; field bit index = row*COLS + col.
- SPAWN_COL, 8, anchor column of each newly spawned piece.

Ports:
- clock  in  1  system clock (50 MHz); the only clock.
- resetn  in  1  synchronous active-low reset, sampled on the rising edge of clock.
- left_key  in  1  move-left level.
- right_key  in  1  move-right level.
- rotate_key  in  1  rotate level.
- drop_tick  in  1  gravity request level, already synchronous to clock.
- hard_drop  in  1  hard-drop level; used only with HARD_DROP_EN.
- random  in  3  piece select; 0-4 direct, 5/6/7 map to 0/1/2.
- field  out  ROWS*COLS  locked cells OR active-piece cells.
- piece_type  out  3  type of the active piece.
- lines_cleared  out  16  count of cleared rows, saturating at 65535.
- game_over  out  1  high once a spawn collides.

Behaviour:
- Reset (resetn low at an edge): locked field=0, piece invalid, field=0, piece_type=0, lines_cleared=0, game_over=0, pending flags=0, state=IDLE.
- Input edges: each key/tick input is registered. A rising edge (high now, low last cycle) sets that input's pending flag. A flag holds until serviced; repeated edges while pending are merged.
- Pieces live in a 4x4 box at anchor (row, col); col is signed.
  - O (0): cells (0,1)(0,2)(1,1)(1,2).
  - I (1): cells (1,0)(1,1)(1,2)(1,3).
  - T (2): cells (0,1)(1,0)(1,1)(1,2).
  - L (3): cells (0,2)(1,0)(1,1)(1,2).
  - S (4): cells (0,1)(0,2)(1,0)(1,1).
- Clockwise rotation: O unchanged; I maps (r,c)->(c,3-r); T, L, S map (r,c)->(c,2-r). Rotation state is 2 bits and wraps 3->0.
- Collision: a candidate position collides if any cell has col<0, col>=COLS, row>=ROWS, or overlaps a locked cell. The check is combinational on the candidate position.
- FSM:
  - IDLE: go to SPAWN the cycle after reset releases.
  - SPAWN: latch the mapped random value; anchor=(0, SPAWN_COL); rotation=0. If the spawn position collides, go to GAME_OVER; otherwise clear all pending flags and go to PLAY.
  - PLAY: service one pending flag per cycle, priority tick > rotate > left > right; lower flags stay pending.
    - Tick: if row+1 is free, move down; if blocked, go to LOCK.
    - Rotate / left / right: apply if free, otherwise discard. The flag clears either way.
  - LOCK: OR the piece cells into the locked field, mark the piece invalid, set scan row = ROWS-1, go to CLEAR_SCAN.
  - CLEAR_SCAN: if the scan row is full, go to CLEAR_SHIFT. Otherwise, if scan row = 0 go to SPAWN, else decrement scan row and stay.
  - CLEAR_SHIFT: in one cycle, rows 0..scan-1 move down one and row 0 is cleared. Increment lines_cleared (saturating). Return to CLEAR_SCAN on the same row.
  - GAME_OVER: game_over=1; field frozen; all inputs ignored until reset.
- Latency: an input edge sampled at edge k is serviced at edge k+1; field reflects the new position after edge k+1.
- Edges arriving outside PLAY stay pending until SPAWN clears them.
- Reset mid-operation (any state, including CLEAR_SHIFT) returns everything to reset values at that edge.

Optional Feature:
- HARD_DROP_EN defined:
  - A hard_drop edge sets a pending flag with priority above tick.
  - When serviced, enter state DROP, which moves the piece down one row per cycle until blocked, then goes to LOCK.
  - DROP ignores other flags; they are retained.
- HARD_DROP_EN undefined: hard_drop is ignored and no DROP state exists.

Test Plan:
- Reset release with random=0 -> after SPAWN, field has exactly bits 9, 10, 29, 30 set; piece_type=0; game_over=0.
- O piece, 18 drop_tick edges -> anchor row 18, bits 369, 370, 389, 390 set. 19th edge -> LOCK, cells persist, a new piece spawns, lines_cleared=0.
- random=1 (I), one rotate edge -> vertical column 10 at rows 0-3 (bits 10, 30, 50, 70). Left edges at cols 0 and beyond -> piece stops at col 0, further lefts discarded.
- Five horizontal I pieces placed at cols 0, 4, 8, 12, 16 and dropped to row 19 -> row 19 cleared, lines_cleared=1, field bits 380-399 all 0 after shift.
- rotate and left edges in the same cycle as drop_tick -> move down first, rotate next cycle, left the cycle after.
- Stack pieces until a spawn collides -> game_over=1; later key edges leave field unchanged. Reset mid-CLEAR_SHIFT -> all outputs 0 next cycle.
